// File: rtl/score_pulse_gen_pkg.sv
// Shared types and constants for the line-clear score pulse generator.
package tetris_score_pkg;

    typedef logic [7:0] points_t;
    typedef logic [2:0] lines_t;

    // Largest single-event award (4 lines, level 15, back-to-back bonus).
    localparam int MAX_EVENT_PTS = 192;

    // Indexed directly by the 3-bit line count; codes 5..7 score nothing.
    localparam logic [3:0] BASE_PTS [0:7] = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd8, 4'd0, 4'd0, 4'd0};

endpackage

// File: rtl/score_pulse_gen_if.sv
// Engine-to-scorer line-clear event handshake.
interface score_pulse_gen_if
    import tetris_score_pkg::*;
#(
    parameter int LEVEL_W = 4
) ();

    logic               clr_valid;
    logic               clr_ready;
    lines_t             clr_lines;
    logic [LEVEL_W-1:0] level;

    modport master (output clr_valid, clr_lines, level, input clr_ready);
    modport slave  (input clr_valid, clr_lines, level, output clr_ready);

endinterface

// File: rtl/score_pulse_gen_calc.sv
// Combinational award for one line-clear event: BASE[lines]*(level+1),
// plus half again for a back-to-back 4-line clear.
module score_points_calc
    import tetris_score_pkg::*;
#(
    parameter int LEVEL_W = 4
) (
    input  lines_t             lines,
    input  logic [LEVEL_W-1:0] level,
    input  logic               b2b,
    output points_t            points
);

    localparam int PW = LEVEL_W + 5;

    logic [PW-1:0] w_base;
    logic [PW-1:0] w_mul;
    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_bonus;

    assign w_base  = PW'(BASE_PTS[lines]);
    assign w_mul   = PW'(level) + PW'(1);
    assign w_prod  = w_base * w_mul;
    assign w_bonus = (b2b && (lines == 3'd4)) ? (w_prod >> 1) : '0;
    assign points  = points_t'(w_prod + w_bonus);

endmodule

// File: rtl/score_pulse_gen.sv
// Turns accepted line-clear events into 1-cycle score pulses via a pending
// accumulator. Define SCORE_B2B_EN to enable the back-to-back 4-line bonus.
module score_pulse_gen
    import tetris_score_pkg::*;
#(
    parameter int LEVEL_W = 4,
    parameter int PEND_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    score_pulse_gen_if.slave  clr_if,
    input  logic              hold,
    output logic              score,
    output logic              busy,
    output logic [PEND_W-1:0] pending
);

    // Worst case: pending at the limit plus one maximal event still fits.
    localparam int READY_LIM = (2 ** PEND_W) - 1 - MAX_EVENT_PTS;

    logic              r_vld_p0;
    points_t           r_pts_p0;
    logic [PEND_W-1:0] r_pend;
    logic              r_score;

    logic              w_b2b;
    points_t           w_pts;
    points_t           w_add;
    logic [PEND_W:0]   w_sum;
    logic [PEND_W:0]   w_next;
    logic              w_ready;
    logic              w_accept;
    logic              w_emit;

    function automatic logic [PEND_W-1:0] sat_pend(input logic [PEND_W:0] v);
        return v[PEND_W] ? '1 : v[PEND_W-1:0];
    endfunction

`ifdef SCORE_B2B_EN
    logic r_b2b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b2b <= 1'b0;
        end else if (w_accept) begin
            if (clr_if.clr_lines == 3'd4) begin
                r_b2b <= 1'b1;
            end else if (clr_if.clr_lines != 3'd0 && clr_if.clr_lines < 3'd4) begin
                r_b2b <= 1'b0;
            end
        end
    end

    assign w_b2b = r_b2b;
`else
    assign w_b2b = 1'b0;
`endif

    score_points_calc #(
        .LEVEL_W (LEVEL_W)
    ) u_calc (
        .lines  (clr_if.clr_lines),
        .level  (clr_if.level),
        .b2b    (w_b2b),
        .points (w_pts)
    );

    assign w_add    = r_vld_p0 ? r_pts_p0 : '0;
    assign w_sum    = {1'b0, r_pend} + {{(PEND_W + 1 - 8){1'b0}}, w_add};
    assign w_ready  = (w_sum <= (PEND_W + 1)'(READY_LIM));
    assign w_accept = clr_if.clr_valid && w_ready;
    assign w_emit   = (r_pend != '0) && !hold;
    // emit is only ever set when pending is nonzero, so this cannot wrap below zero
    assign w_next   = w_sum - {{PEND_W{1'b0}}, w_emit};

    // Stage p0: event points captured at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pts_p0 <= w_pts;
        end
    end

    // Accumulator and pulse output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= '0;
            r_score <= 1'b0;
        end else begin
            r_pend  <= sat_pend(w_next);
            r_score <= w_emit;
        end
    end

    assign clr_if.clr_ready = w_ready;
    assign score            = r_score;
    assign busy             = (r_pend != '0) || r_vld_p0;
    assign pending          = r_pend;

endmodule

// File: tb/tb_score_pulse_gen.sv
// Scoreboard bench for score_pulse_gen: event-level reference model plus
// directed scenarios and a randomized event stream.
module tb_score_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        score;
    logic        busy;
    logic [11:0] pending;

    score_pulse_gen_if #(.LEVEL_W(4)) bus ();

    score_pulse_gen #(
        .LEVEL_W (4),
        .PEND_W  (12)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clr_if  (bus),
        .hold    (hold),
        .score   (score),
        .busy    (busy),
        .pending (pending)
    );

    always #5 clk = ~clk;

`ifdef SCORE_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int LIMIT = 4095 - 192;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pulse = 0;
    int first_pulse_cyc = -1;
    int burst_first = -1;
    int burst_last = -1;
    int last_acc_cyc = 0;
    bit mon_en = 1'b0;

    // reference model state
    int m_pend = 0;
    int m_pts = 0;
    bit m_svld = 1'b0;
    bit m_b2b = 1'b0;
    bit m_score = 1'b0;
    bit m_acc;
    bit m_emit;
    int m_nxt;
    int m_p;
    int q_tok[$];

    function automatic int ref_pts(input int lines, input int lvl, input bit b2b);
        int base;
        int p;
        case (lines)
            1: base = 1;
            2: base = 3;
            3: base = 5;
            4: base = 8;
            default: base = 0;
        endcase
        p = base * (lvl + 1);
        if (B2B && b2b && lines == 4) p = (p * 3) / 2;
        return p;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: evaluated on each rising edge with pre-edge inputs
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_pend = 0; m_pts = 0; m_svld = 0; m_b2b = 0; m_score = 0;
            q_tok.delete();
        end else begin
            m_acc  = (bus.clr_valid === 1'b1) && (m_pend + (m_svld ? m_pts : 0) <= LIMIT);
            m_emit = (m_pend != 0) && !hold;
            m_nxt  = m_pend - int'(m_emit) + (m_svld ? m_pts : 0);
            if (m_nxt > 4095) m_nxt = 4095;
            m_score = m_emit;
            m_pend  = m_nxt;
            if (m_acc) begin
                m_p    = ref_pts(int'(bus.clr_lines), int'(bus.level), m_b2b);
                m_pts  = m_p;
                m_svld = 1'b1;
                for (int i = 0; i < m_p; i++) q_tok.push_back(cyc);
                if (bus.clr_lines == 3'd4) m_b2b = 1'b1;
                else if (bus.clr_lines >= 3'd1 && bus.clr_lines <= 3'd3) m_b2b = 1'b0;
            end else begin
                m_svld = 1'b0;
                m_pts  = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the model on falling edges
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk(score === m_score, "score", int'(score), int'(m_score));
            chk(pending === 12'(m_pend), "pending", int'(pending), m_pend);
            chk(busy === ((m_pend != 0) || m_svld), "busy", int'(busy), int'((m_pend != 0) || m_svld));
            chk(bus.clr_ready === (m_pend + (m_svld ? m_pts : 0) <= LIMIT), "clr_ready",
                int'(bus.clr_ready), int'(m_pend + (m_svld ? m_pts : 0) <= LIMIT));
            if (score === 1'b1) begin
                n_pulse++;
                if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
                if (burst_first < 0) burst_first = cyc;
                burst_last = cyc;
                chk(q_tok.size() > 0, "pulse_token", q_tok.size(), 1);
                if (q_tok.size() > 0) void'(q_tok.pop_front());
            end
        end
    end

    task automatic send(input int lines, input int lvl);
        bit ok;
        ok = 1'b0;
        bus.clr_valid = 1'b1;
        bus.clr_lines = 3'(lines);
        bus.level     = 4'(lvl);
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(posedge clk);
            ok = (bus.clr_ready === 1'b1);
            #1;
        end
        last_acc_cyc  = cyc;
        bus.clr_valid = 1'b0;
        if (!ok) chk(ok, "send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk(i < 8000, name, i, 8000);
    endtask

    task automatic burst(input int lines, input int lvl, input int exp_n, input string name);
        int base;
        base = n_pulse;
        send(lines, lvl);
        wait_idle({name, "_idle"});
        chk(n_pulse - base == exp_n, name, n_pulse - base, exp_n);
    endtask

    initial begin
        int base;
        int acc_pts;
        bit saw_nr;
        int i;
        bus.clr_valid = 1'b0;
        bus.clr_lines = 3'd0;
        bus.level     = 4'd0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk(pending === 12'd0 && score === 1'b0, "reset_state", int'(pending), 0);
        chk(bus.clr_ready === 1'b1, "reset_ready", int'(bus.clr_ready), 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // single point, latency 2
        base = n_pulse;
        send(1, 0);
        base = last_acc_cyc;
        wait_idle("t1_idle");
        chk(n_pulse == 1, "t1_count", n_pulse, 1);
        chk(first_pulse_cyc - base == 2, "t1_latency", first_pulse_cyc - base, 2);
        chk(busy === 1'b0, "t1_busy_drop", int'(busy), 0);

        // 24 pulses, pending walks down
        base = n_pulse;
        send(4, 2);
        @(negedge clk);
        for (int v = 24; v >= 0; v--) begin
            @(negedge clk);
            chk(pending === 12'(v), "t2_pending_walk", int'(pending), v);
        end
        wait_idle("t2_idle");
        chk(n_pulse - base == 24, "t2_count", n_pulse - base, 24);

        // back-to-back events merge with no gap
        base = n_pulse;
        burst_first = -1;
        send(2, 0);
        send(3, 1);
        wait_idle("t3_idle");
        chk(n_pulse - base == 13, "t3_count", n_pulse - base, 13);
        chk(burst_last - burst_first + 1 == 13, "t3_no_gap", burst_last - burst_first + 1, 13);

        // hold after five pulses
        base = n_pulse;
        send(3, 3);
        for (i = 0; i < 200 && n_pulse - base < 5; i++) @(negedge clk);
        chk(n_pulse - base == 5, "t4_first5", n_pulse - base, 5);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk(pending === 12'd15, "t4_frozen", int'(pending), 15);
            chk(score === 1'b0, "t4_no_pulse", int'(score), 0);
        end
        hold = 1'b0;
        wait_idle("t4_idle");
        chk(n_pulse - base == 20, "t4_count", n_pulse - base, 20);

        // fill under hold until back-pressure
        base = n_pulse;
        acc_pts = 0;
        saw_nr = 1'b0;
        @(posedge clk);
        #1 hold = 1'b1;
        bus.clr_lines = 3'd4;
        bus.level     = 4'd15;
        bus.clr_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (bus.clr_ready === 1'b1) acc_pts += 128;
            else saw_nr = 1'b1;
            #1;
        end
        bus.clr_valid = 1'b0;
        @(negedge clk);
        chk(saw_nr, "t5_backpressure", int'(saw_nr), 1);
        chk(acc_pts == 31 * 128, "t5_accepted", acc_pts, 31 * 128);
        chk(pending === 12'(31 * 128), "t5_pending_peak", int'(pending), 31 * 128);
        hold = 1'b0;
        wait_idle("t5_idle");
        chk(n_pulse - base == acc_pts, "t5_count", n_pulse - base, acc_pts);

        // back-to-back bonus sequence
        burst(1, 0, 1, "t6_clear_flag");
        burst(4, 0, 8, "t6_first_tetris");
        burst(4, 0, B2B ? 12 : 8, "t6_second_tetris");
        burst(1, 0, 1, "t6_single");
        burst(4, 0, 8, "t6_after_single");
        burst(0, 9, 0, "t6_zero_lines");
        burst(6, 9, 0, "t6_bad_lines");

        // reset mid-emission
        base = n_pulse;
        send(4, 3);
        for (i = 0; i < 200 && n_pulse - base < 5; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk(score === 1'b0, "rst_score", int'(score), 0);
        chk(pending === 12'd0, "rst_pending", int'(pending), 0);
        reset = 1'b0;
        base = n_pulse;
        repeat (10) @(negedge clk);
        chk(n_pulse == base, "rst_no_pulses", n_pulse - base, 0);

        // randomized event stream
        for (int e = 0; e < 150; e++) begin
            hold = ($urandom_range(0, 3) == 0) && (pending < 12'd3000);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            send($urandom_range(0, 7), $urandom_range(0, 15));
        end
        hold = 1'b0;
        wait_idle("rand_idle");
        chk(q_tok.size() == 0, "rand_tokens_left", q_tok.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
